snes_pad_resp: RTL and testbench
================================

Name: snes_pad_resp

Overview:
- Controller-side responder for the SNES joypad serial port.
- It is the device end of the JOY_STRB / JOYx_CLK / JOYx_DI link that the console core drives and samples.
- Latches button state on strobe, then serialises it bit by bit on each port clock pulse.
- Used in simulation benches, and as a synthesizable pad/multitap model feeding the SNES core's joypad data inputs.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for JOY_STRB, JOY_CLK and JOY_P6 (minimum 2).
- PAD_ID, 4'b0000: logical value of serial bits 12..15; 0000 = standard pad.

Ports:
- CLK  in  1: system clock (MCLK domain).
- RESET  in  1: asynchronous, active-high reset.
- BTN_A  in  12: logical pad A buttons, 1 = pressed. Order [0..11] = B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R.
- BTN_B  in  12: pad B, same order (multitap only).
- BTN_C  in  12: pad C (multitap only).
- BTN_D  in  12: pad D (multitap only).
- JOY_STRB  in  1: latch strobe from console, asynchronous to CLK.
- JOY_CLK  in  1: serial clock from console, idle high, asynchronous.
- JOY_P6  in  1: IO bit from console (multitap select).
- JOY_DO  out  2: wire-level data lines to the console's JOYx_DI. Active-low: wire 0 = logical 1.

Behaviour:
- Synchronisation and edges:
  - JOY_STRB, JOY_CLK and JOY_P6 each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised values only.
  - Response latency from an input pin change to a JOY_DO change = SYNC_STAGES+1 CLK cycles.
- Reset (async, RESET=1):
  - Shift registers cleared to all logical 0.
  - Bit counter = 0.
  - JOY_DO = 2'b11 (logical 0 on both lines).
  - Synchroniser flops reset to JOY_CLK=1, STRB=0, P6=1.
  - Reset asserted mid-transfer aborts the transfer; the next read requires a fresh strobe.
- Frame format per pad: 16 bits = {PAD_ID[3:0] as bits 15..12, BTN[11:0]}, shifted out LSB first.
- State machine (LOAD, SHIFT, DONE):
  - LOAD (synced STRB=1):
    - Shift register(s) reload from BTN_* every CLK cycle; counter = 0.
    - JOY_DO[0] = ~BTN bit 0 of the selected pad.
    - Clock edges are ignored.
  - LOAD -> SHIFT on STRB falling edge; the value loaded in the cycle before the fall is held.
  - SHIFT: on each synced JOY_CLK rising edge:
    - Shift right by one, insert logical 1 at the MSB, counter++.
    - JOY_DO updates in the cycle after the edge.
  - SHIFT -> DONE when the counter reaches 16.
  - DONE: JOY_DO[0] holds logical 1 (wire 0). Further clock edges are ignored; the counter saturates at 16.
  - Any state -> LOAD whenever synced STRB=1.
- Boundary cases:
  - STRB rising coincident with a CLK rising edge: strobe wins, reload, no shift.
  - A clock edge arriving without a preceding strobe, after reset, shifts the reset (all 0) contents, so logical 0 bits are followed by 1s.
- Width: counter is 5 bits, saturating. No wrap to 0 except via strobe or reset.

Optional Feature:
- Macro: SNES_MULTITAP_EN.
- Enabled:
  - Four 16-bit shift registers (A..D), all latched together in LOAD and all shifting together.
  - Synced P6=1: JOY_DO[0] = pad A, JOY_DO[1] = pad B.
  - Synced P6=0: JOY_DO[0] = pad C, JOY_DO[1] = pad D.
  - Lane selection is combinational on synced P6 at output-register time.
  - While STRB=1, JOY_DO[1] = wire 0 (logical 1, multitap-present signature).
- Disabled:
  - Only pad A is implemented.
  - JOY_DO[1] = 1 (logical 0) constant.
  - JOY_P6 and BTN_B..BTN_D are ignored; their synchronisers are not instantiated.

Decomposition:
- Package snes_pad_pkg:
  - Button index constants (BTN_IDX_B .. BTN_IDX_R).
  - PAD_BITS = 16.
  - State enum {LOAD, SHIFT, DONE}.
- Sub-module snes_pad_shreg: one 16-bit load/shift register with MSB fill-1, instantiated once without the macro and four times with it.
- The top level owns the synchronisers, edge detect, FSM, counter and output mux/register.

Test Plan:
- Reset mid-transfer after 5 clocks -> JOY_DO=2'b11 immediately. Next strobe+16 clocks with BTN_A=12'h000 yields 16 logical 0s.
- BTN_A=12'h881 (B, Right, R), strobe, 16 clocks -> logical stream 1,0,0,0,0,0,0,1,0,0,0,1,0,0,0,0. Then clocks 17..20 read logical 1.
- PAD_ID=4'b1010, BTN_A=0 -> bits 12..15 read 0,1,0,1. BTN_A toggled after the STRB fall does not affect the stream.
- Clock edge coincident with STRB high -> no shift. After the STRB fall, first read is bit 0 of the current BTN_A.
- SNES_MULTITAP_EN, BTN_A=1, BTN_B=2, BTN_C=4, BTN_D=8:
  - STRB high -> D1 wire 0.
  - P6=1 first two bits: D0 logical 1,0 and D1 0,1.
  - P6=0: D0 bit 2 = 1, D1 bit 3 = 1.
- Macro off: JOY_DO[1] stays 1 under all P6/BTN_B..D activity.

Source files
------------

// File: rtl/snes_pad_pkg.sv
// Shared constants and state type for the SNES joypad responder.
package snes_pad_pkg;
    localparam int PAD_BITS = 16;
    localparam int BTN_BITS = 12;
    localparam logic [4:0] CNT_FULL = 5'd16;

    localparam int BTN_IDX_B      = 0;
    localparam int BTN_IDX_Y      = 1;
    localparam int BTN_IDX_SELECT = 2;
    localparam int BTN_IDX_START  = 3;
    localparam int BTN_IDX_UP     = 4;
    localparam int BTN_IDX_DOWN   = 5;
    localparam int BTN_IDX_LEFT   = 6;
    localparam int BTN_IDX_RIGHT  = 7;
    localparam int BTN_IDX_A      = 8;
    localparam int BTN_IDX_X      = 9;
    localparam int BTN_IDX_L      = 10;
    localparam int BTN_IDX_R      = 11;

    typedef enum logic [1:0] {LOAD, SHIFT, DONE} pad_state_e;
endpackage

// File: rtl/snes_pad_shreg.sv
// One pad's 16-bit frame register: parallel load, shift right with logical-1 fill.
module snes_pad_shreg
    import snes_pad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [PAD_BITS-1:0] din,
    output logic                lsb_next
);
    logic [PAD_BITS-1:0] q, q_next;

    always_comb begin
        q_next = q;
        if (load)
            q_next = din;
        else if (shift)
            q_next = {1'b1, q[PAD_BITS-1:1]};
    end

    // The output register upstream wants the bit that will be current after this edge.
    assign lsb_next = q_next[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else
            q <= q_next;
    end
endmodule

// File: rtl/snes_pad_resp.sv
// SNES joypad device-side responder. Define SNES_MULTITAP_EN for the four-pad multitap model.
module snes_pad_resp
    import snes_pad_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] PAD_ID      = 4'b0000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [BTN_BITS-1:0] BTN_A,
    input  logic [BTN_BITS-1:0] BTN_B,
    input  logic [BTN_BITS-1:0] BTN_C,
    input  logic [BTN_BITS-1:0] BTN_D,
    input  logic                JOY_STRB,
    input  logic                JOY_CLK,
    input  logic                JOY_P6,
    output logic [1:0]          JOY_DO
);
`ifdef SNES_MULTITAP_EN
    localparam int NUM_PADS = 4;
`else
    localparam int NUM_PADS = 1;
`endif

    logic [SYNC_STAGES-1:0] strb_sync, clk_sync;
    logic strb_s, clk_s, clk_q, clk_rise;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            strb_sync <= '0;
            clk_sync  <= '1;
            clk_q     <= 1'b1;
        end else begin
            strb_sync <= {strb_sync[SYNC_STAGES-2:0], JOY_STRB};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], JOY_CLK};
            clk_q     <= clk_s;
        end
    end

    assign strb_s   = strb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_q;

`ifdef SNES_MULTITAP_EN
    logic [SYNC_STAGES-1:0] p6_sync;
    logic p6_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            p6_sync <= '1;
        else
            p6_sync <= {p6_sync[SYNC_STAGES-2:0], JOY_P6};
    end
    assign p6_s = p6_sync[SYNC_STAGES-1];
`else
    logic unused_inputs;
    assign unused_inputs = ^{BTN_B, BTN_C, BTN_D, JOY_P6};
`endif

    pad_state_e state, state_nx;
    logic [4:0] cnt, cnt_nx;
    logic load, shift;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= SHIFT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Strobe dominates everything, including a coincident clock edge.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        shift    = 1'b0;
        if (strb_s) begin
            state_nx = LOAD;
            cnt_nx   = '0;
            load     = 1'b1;
        end else begin
            unique case (state)
                LOAD:  state_nx = SHIFT;
                SHIFT: if (clk_rise) begin
                    shift  = 1'b1;
                    cnt_nx = (cnt == CNT_FULL) ? cnt : cnt + 5'd1;
                    if (cnt_nx == CNT_FULL)
                        state_nx = DONE;
                end
                default: ;
            endcase
        end
    end

    logic [NUM_PADS-1:0][BTN_BITS-1:0] btn;
    logic [NUM_PADS-1:0] lsb_next;

`ifdef SNES_MULTITAP_EN
    assign btn = {BTN_D, BTN_C, BTN_B, BTN_A};
`else
    assign btn[0] = BTN_A;
`endif

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        snes_pad_shreg u_shreg (
            .clk      (CLK),
            .rst      (RESET),
            .load     (load),
            .shift    (shift),
            .din      ({PAD_ID, btn[i]}),
            .lsb_next (lsb_next[i])
        );
    end

    logic [1:0] do_nx;

    always_comb begin
`ifdef SNES_MULTITAP_EN
        do_nx = p6_s ? {~lsb_next[1], ~lsb_next[0]} : {~lsb_next[3], ~lsb_next[2]};
        if (strb_s)
            do_nx[1] = 1'b0;
`else
        do_nx = {1'b1, ~lsb_next[0]};
`endif
        if (state_nx == DONE)
            do_nx[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            JOY_DO <= 2'b11;
        else
            JOY_DO <= do_nx;
    end
endmodule

// File: tb/tb_snes_pad_resp.sv
// Directed bench for snes_pad_resp; a second instance covers a non-zero PAD_ID.
module tb_snes_pad_resp;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [11:0] BTN_A, BTN_B, BTN_C, BTN_D;
    logic        JOY_STRB, JOY_CLK, JOY_P6;
    logic [1:0]  do_a, do_id;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    snes_pad_resp u_dut (
        .CLK(CLK), .RESET(RESET), .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_C(BTN_C), .BTN_D(BTN_D),
        .JOY_STRB(JOY_STRB), .JOY_CLK(JOY_CLK), .JOY_P6(JOY_P6), .JOY_DO(do_a)
    );

    snes_pad_resp #(.PAD_ID(4'b1010)) u_dut_id (
        .CLK(CLK), .RESET(RESET), .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_C(BTN_C), .BTN_D(BTN_D),
        .JOY_STRB(JOY_STRB), .JOY_CLK(JOY_CLK), .JOY_P6(JOY_P6), .JOY_DO(do_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic strobe();
        JOY_STRB = 1'b1;
        cyc(6);
        JOY_STRB = 1'b0;
        cyc(6);
    endtask

    task automatic pclk();
        JOY_CLK = 1'b0;
        cyc(4);
        JOY_CLK = 1'b1;
        cyc(5);
    endtask

    // Logical stream: bit 0 is visible right after the strobe, each clock exposes the next.
    task automatic read_stream(input string tag, input logic [15:0] exp_a, input logic [15:0] exp_id);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) pclk();
            chk($sformatf("%s a b%0d", tag, i), !do_a[0], exp_a[i]);
            chk($sformatf("%s id b%0d", tag, i), !do_id[0], exp_id[i]);
        end
    endtask

    initial begin
        RESET = 1'b1;
        JOY_STRB = 1'b0; JOY_CLK = 1'b1; JOY_P6 = 1'b1;
        BTN_A = '0; BTN_B = '0; BTN_C = '0; BTN_D = '0;
        cyc(3);
        chk("reset do_a", do_a, 2'b11);
        chk("reset do_id", do_id, 2'b11);
        RESET = 1'b0;
        cyc(2);

        // Clocks without a strobe shift out the cleared register, then the 1 fill.
        for (int i = 0; i < 15; i++) pclk();
        chk("nostrb clk15", !do_a[0], 1'b0);
        pclk();
        chk("nostrb clk16", !do_a[0], 1'b1);

        BTN_A = 12'h881;
        strobe();
        read_stream("s881", 16'h0881, 16'hA881);
        for (int i = 17; i <= 20; i++) begin
            pclk();
            chk($sformatf("s881 clk%0d", i), !do_a[0], 1'b1);
        end

        // Buttons changed after the strobe fall must not leak into the frame.
        BTN_A = 12'h000;
        strobe();
        BTN_A = 12'hFFF;
        read_stream("padid", 16'h0000, 16'hA000);

        // Port clock pulses while strobe is high are ignored.
        BTN_A = 12'h0FE;
        JOY_STRB = 1'b1;
        cyc(1);
        JOY_CLK = 1'b0;
        cyc(4);
        JOY_CLK = 1'b1;
        cyc(2);
        BTN_A = 12'h001;
        cyc(4);
        chk("load d0", !do_a[0], 1'b1);
`ifdef SNES_MULTITAP_EN
        chk("load d1 sig", do_a[1], 1'b0);
`else
        chk("load d1", do_a[1], 1'b1);
`endif
        JOY_STRB = 1'b0;
        cyc(6);
        chk("coinc b0", !do_a[0], 1'b1);
        pclk();
        chk("coinc b1", !do_a[0], 1'b0);

        // Reset mid-transfer aborts; a fresh strobe starts over.
        BTN_A = 12'h881;
        strobe();
        for (int i = 0; i < 5; i++) pclk();
        RESET = 1'b1;
        #1;
        chk("midrst do_a", do_a, 2'b11);
        chk("midrst do_id", do_id, 2'b11);
        cyc(2);
        RESET = 1'b0;
        cyc(2);
        BTN_A = 12'h000;
        strobe();
        read_stream("postrst", 16'h0000, 16'hA000);

`ifdef SNES_MULTITAP_EN
        BTN_A = 12'h001; BTN_B = 12'h002; BTN_C = 12'h004; BTN_D = 12'h008;
        JOY_P6 = 1'b1;
        JOY_STRB = 1'b1;
        cyc(6);
        chk("mt strb d1", do_a[1], 1'b0);
        JOY_STRB = 1'b0;
        cyc(6);
        chk("mt p6h d0 b0", !do_a[0], 1'b1);
        chk("mt p6h d1 b0", !do_a[1], 1'b0);
        pclk();
        chk("mt p6h d0 b1", !do_a[0], 1'b0);
        chk("mt p6h d1 b1", !do_a[1], 1'b1);
        JOY_P6 = 1'b0;
        cyc(5);
        pclk();
        chk("mt p6l d0 b2", !do_a[0], 1'b1);
        chk("mt p6l d1 b2", !do_a[1], 1'b0);
        pclk();
        chk("mt p6l d0 b3", !do_a[0], 1'b0);
        chk("mt p6l d1 b3", !do_a[1], 1'b1);
`else
        BTN_B = 12'hFFF; BTN_C = 12'hFFF; BTN_D = 12'hFFF;
        JOY_P6 = 1'b0;
        JOY_STRB = 1'b1;
        cyc(6);
        chk("nomt strb d1", do_a[1], 1'b1);
        JOY_STRB = 1'b0;
        cyc(6);
        chk("nomt p6l d1", do_a[1], 1'b1);
        pclk();
        chk("nomt shift d1", do_a[1], 1'b1);
        JOY_P6 = 1'b1;
        cyc(5);
        pclk();
        chk("nomt p6h d1", do_a[1], 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
